pipe_stage_skid: RTL

//  Generic, parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready
//   backpressure through a 2-entry skid buffer. in_ready comes only from registered state
//   and the reset input, so a downstream stall never forms a combinational path upstream.
//   A flush turns the stage into a bubble: control is zeroed, and data passes through for
//   debug/trace.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating stall_cnt/flush_cnt
// performance counters. Without it, those ports and their logic do not exist.
//
// Parameters
//   CTRL_W  control payload width (zeroed on flush/bubble)
//   DATA_W  data payload width (carried through on flush)
//   CNT_W   perf counter width (only meaningful with PIPE_STAGE_PERF_EN)
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-low
//   flush      in   kill stage contents this cycle
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept (reset & ~skid_valid)
//   in_ctrl    in   upstream control payload
//   in_data    in   upstream data payload
//   out_valid  out  out_ctrl/out_data hold a valid entry
//   out_ready  in   downstream accepts (0 = stall)
//   out_ctrl   out  registered control, all 0 whenever out_valid=0
//   out_data   out  registered data, holds last value when the stage empties
//   stall_cnt  out  cycles with out_valid & ~out_ready (PIPE_STAGE_PERF_EN only)
//   flush_cnt  out  flushes that discarded a stored entry (PIPE_STAGE_PERF_EN only)

module pipe_stage_skid #(
   parameter int unsigned CTRL_W = 6,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // State encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StBusy  = 2'b10,
      StFull  = 2'b11
   } state_e;

   state_e            state_q;
   logic [CTRL_W-1:0] skid_ctrl_q;
   logic [DATA_W-1:0] skid_data_q;

   logic skid_valid;
   logic accept;
   logic drain;

   assign out_valid  = state_q[1];
   assign skid_valid = state_q[0];

   // Only the reset pin and a register feed in_ready; out_ready never reaches it.
   assign in_ready = reset & ~skid_valid;
   assign accept   = in_valid & in_ready;
   assign drain    = out_valid & out_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StEmpty;
         out_ctrl    <= '0;
         out_data    <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else if (flush) begin
         // Bubble: both stored entries and any entry offered this cycle are dropped.
         state_q     <= StEmpty;
         out_ctrl    <= '0;
         out_data    <= in_data;
         skid_ctrl_q <= '0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_q  <= StBusy;
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end
            end
            StBusy: begin
               if (accept && drain) begin
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end else if (accept) begin
                  // Output is stalled; park the new entry behind it.
                  state_q     <= StFull;
                  skid_ctrl_q <= in_ctrl;
                  skid_data_q <= in_data;
               end else if (drain) begin
                  // Going empty: kill control but keep data for trace.
                  state_q  <= StEmpty;
                  out_ctrl <= '0;
               end
            end
            StFull: begin
               if (drain) begin
                  state_q     <= StBusy;
                  out_ctrl    <= skid_ctrl_q;
                  out_data    <= skid_data_q;
                  skid_ctrl_q <= '0;
               end
            end
            default: begin
               state_q     <= StEmpty;
               out_ctrl    <= '0;
               skid_ctrl_q <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic stall_evt;
   logic flush_evt;

   assign stall_evt = out_valid & ~out_ready;
   // skid_valid implies out_valid, so out_valid alone marks "something stored".
   assign flush_evt = flush & out_valid;

   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_evt && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
